// File: rtl/hyperram_lb_bridge.sv
// Local-bus register front end that issues single-word HyperRAM requests; reads return registered data one cycle after lb_rd.
// One request in flight; register writes to ADDR/DATA/CMD while busy are dropped and flagged, stalled core aborts after TIMEOUT cycles.
module hyperram_lb_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lb_wr,
  input  logic        lb_rd,
  input  logic [31:0] lb_addr,
  input  logic [31:0] lb_wr_d,
  output logic [31:0] lb_rd_d,
  output logic        lb_rd_rdy,
  output logic        busy,
  output logic        hr_req,
  output logic        hr_we,
  output logic [31:0] hr_addr,
  output logic [31:0] hr_wdata,
  input  logic        hr_ack,
  input  logic        hr_rvalid,
  input  logic [31:0] hr_rdata
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [31:0] A_ADDR   = 32'h10;
  localparam logic [31:0] A_DATA   = 32'h14;
  localparam logic [31:0] A_STATUS = 32'h18;
  localparam logic [31:0] A_CMD    = 32'h1C;
  localparam logic [31:0] A_COUNT  = 32'h20;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   addr_q, wdata_q, rdata_q, count_q, rd_mux;
  logic          op_we_q, st_tmo, st_ovr;
  logic          idle, wr_addr, wr_data, wr_cmd, wr_status;
  logic          cmd_go, tmo_hit, done, abort, ovr_set;

  assign idle      = (state == IDLE);
  assign wr_addr   = lb_wr && (lb_addr == A_ADDR);
  assign wr_data   = lb_wr && (lb_addr == A_DATA);
  assign wr_cmd    = lb_wr && (lb_addr == A_CMD);
  assign wr_status = lb_wr && (lb_addr == A_STATUS);
  assign cmd_go    = wr_cmd && idle && (lb_wr_d[0] || lb_wr_d[2]);
  assign ovr_set   = !idle && (wr_addr || wr_data || wr_cmd);
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));

  assign busy     = !idle;
  assign hr_req   = (state == REQ);
  assign hr_we    = op_we_q;
  assign hr_addr  = addr_q;
  assign hr_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Completion wins over timeout when both land in the last allowed cycle.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (cmd_go) state_nxt = REQ;
      REQ: begin
        if (hr_ack) begin
          state_nxt = op_we_q ? IDLE : WAIT_RD;
          done      = op_we_q;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      WAIT_RD: begin
        if (hr_rvalid) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                tmo_cnt <= '0;
    else if (state_nxt != state) tmo_cnt <= '0;
    else if (!idle)              tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
      op_we_q <= 1'b0;
      st_tmo  <= 1'b0;
      st_ovr  <= 1'b0;
    end else begin
      if (wr_addr && idle) addr_q <= lb_wr_d;
      if (wr_data && idle) wdata_q <= lb_wr_d;
      if (cmd_go) op_we_q <= lb_wr_d[0];
      if (state == WAIT_RD && hr_rvalid) rdata_q <= hr_rdata;
      if (done) count_q <= count_q + 32'd1;
      if (abort)                      st_tmo <= 1'b1;
      else if (wr_status && lb_wr_d[1]) st_tmo <= 1'b0;
      if (ovr_set)                    st_ovr <= 1'b1;
      else if (wr_status && lb_wr_d[2]) st_ovr <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (lb_addr)
      A_ADDR:   rd_mux = addr_q;
      A_DATA:   rd_mux = rdata_q;
      A_STATUS: rd_mux = {29'd0, st_ovr, st_tmo, busy};
      A_COUNT:  rd_mux = count_q;
      default:  rd_mux = '0;
    endcase
  end

  // Read mux sees pre-write register values, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lb_rd_rdy <= 1'b0;
      lb_rd_d   <= '0;
    end else begin
      lb_rd_rdy <= lb_rd;
      if (lb_rd) lb_rd_d <= rd_mux;
    end
  end

endmodule

// File: tb/tb_hyperram_lb_bridge.sv
// Directed bench for hyperram_lb_bridge: register map, write/read transactions, overrun, timeout and reset behaviour.
module tb_hyperram_lb_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lb_wr = 1'b0, lb_rd = 1'b0;
  logic [31:0] lb_addr = '0, lb_wr_d = '0;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy, busy, hr_req, hr_we;
  logic [31:0] hr_addr, hr_wdata;
  logic        hr_ack = 1'b0, hr_rvalid = 1'b0;
  logic [31:0] hr_rdata = '0;

  int chk_cnt = 0;
  int err_cnt = 0;

  hyperram_lb_bridge #(.TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
    .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy), .busy(busy),
    .hr_req(hr_req), .hr_we(hr_we), .hr_addr(hr_addr), .hr_wdata(hr_wdata),
    .hr_ack(hr_ack), .hr_rvalid(hr_rvalid), .hr_rdata(hr_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lb_write(input logic [31:0] a, input logic [31:0] d);
    lb_addr = a; lb_wr_d = d; lb_wr = 1'b1;
    tick(1);
    lb_wr = 1'b0;
  endtask

  task automatic lb_read(input logic [31:0] a, output logic [31:0] d);
    lb_addr = a; lb_rd = 1'b1;
    tick(1);
    lb_rd = 1'b0;
    chk("rd_rdy", {31'd0, lb_rd_rdy}, 32'd1);
    d = lb_rd_d;
  endtask

  task automatic pulse_ack();
    hr_ack = 1'b1;
    tick(1);
    hr_ack = 1'b0;
  endtask

  task automatic pulse_rvalid(input logic [31:0] d);
    hr_rvalid = 1'b1; hr_rdata = d;
    tick(1);
    hr_rvalid = 1'b0; hr_rdata = '0;
  endtask

  initial begin
    logic [31:0] rd;
    int n;

    // Reset values while reset_n is held low
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, hr_req}, 32'd0);
    chk("rst_we", {31'd0, hr_we}, 32'd0);
    chk("rst_rdy", {31'd0, lb_rd_rdy}, 32'd0);
    chk("rst_rd_d", lb_rd_d, 32'd0);
    chk("rst_hr_addr", hr_addr, 32'd0);
    chk("rst_hr_wdata", hr_wdata, 32'd0);
    #10 reset_n = 1'b1;
    tick(2);
    lb_read(32'h18, rd); chk("rst_status", rd, 32'd0);
    tick(1);
    chk("rdy_one_cycle", {31'd0, lb_rd_rdy}, 32'd0);
    lb_read(32'h20, rd); chk("rst_count", rd, 32'd0);

    // Write transaction, core acks three cycles later
    lb_write(32'h10, 32'h5);
    lb_write(32'h14, 32'hA5A5_1234);
    lb_write(32'h1C, 32'h1);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_req", {31'd0, hr_req}, 32'd1);
    chk("wr_we", {31'd0, hr_we}, 32'd1);
    chk("wr_addr", hr_addr, 32'h5);
    chk("wr_wdata", hr_wdata, 32'hA5A5_1234);
    tick(2);
    chk("wr_req_held", {31'd0, hr_req}, 32'd1);
    pulse_ack();
    chk("wr_req_drop", {31'd0, hr_req}, 32'd0);
    chk("wr_busy_drop", {31'd0, busy}, 32'd0);
    lb_read(32'h20, rd); chk("wr_count", rd, 32'd1);

    // Read transaction
    lb_write(32'h1C, 32'h4);
    chk("rd_req", {31'd0, hr_req}, 32'd1);
    chk("rd_we", {31'd0, hr_we}, 32'd0);
    pulse_ack();
    chk("rd_req_drop", {31'd0, hr_req}, 32'd0);
    chk("rd_wait_busy", {31'd0, busy}, 32'd1);
    tick(2);
    pulse_rvalid(32'hDEAD_BEEF);
    chk("rd_busy_drop", {31'd0, busy}, 32'd0);
    lb_read(32'h14, rd); chk("rd_data", rd, 32'hDEAD_BEEF);
    lb_read(32'h20, rd); chk("rd_count", rd, 32'd2);

    // Writes while a read is in flight are dropped and flagged
    lb_write(32'h1C, 32'h4);
    pulse_ack();
    lb_write(32'h14, 32'h1111);
    lb_write(32'h1C, 32'h1);
    lb_read(32'h18, rd); chk("ovr_status_busy", rd, 32'h5);
    chk("ovr_wdata", hr_wdata, 32'hA5A5_1234);
    pulse_rvalid(32'h1234_5678);
    chk("ovr_idle", {31'd0, busy}, 32'd0);
    tick(3);
    chk("ovr_no_second_req", {31'd0, hr_req | busy}, 32'd0);
    lb_read(32'h14, rd); chk("ovr_rdata", rd, 32'h1234_5678);
    lb_read(32'h20, rd); chk("ovr_count", rd, 32'd3);
    lb_read(32'h18, rd); chk("ovr_status", rd, 32'h4);
    lb_write(32'h18, 32'h4);
    lb_read(32'h18, rd); chk("ovr_clear", rd, 32'h0);

    // Write bit has priority over read bit
    lb_write(32'h1C, 32'h5);
    chk("prio_we", {31'd0, hr_we}, 32'd1);
    pulse_ack();
    chk("prio_idle", {31'd0, busy}, 32'd0);
    tick(3);
    chk("prio_no_read", {31'd0, hr_req | busy}, 32'd0);
    lb_read(32'h20, rd); chk("prio_count", rd, 32'd4);

    // Command with neither bit set is ignored
    lb_write(32'h1C, 32'h2);
    chk("cmd_ignored", {31'd0, busy}, 32'd0);

    // Timeout: no ack, abort after 255 cycles in REQ
    lb_write(32'h1C, 32'h1);
    n = 0;
    while (busy && n < 400) begin
      n++;
      tick(1);
    end
    chk("tmo_cycles", n, 32'd255);
    lb_read(32'h18, rd); chk("tmo_status", rd, 32'h2);
    lb_read(32'h20, rd); chk("tmo_count", rd, 32'd4);
    lb_write(32'h18, 32'h2);
    lb_read(32'h18, rd); chk("tmo_clear", rd, 32'h0);

    // W1C landing on the same edge as the abort: set wins
    lb_write(32'h1C, 32'h1);
    tick(254);
    lb_write(32'h18, 32'h2);
    chk("w1c_race_idle", {31'd0, busy}, 32'd0);
    lb_read(32'h18, rd); chk("w1c_race_status", rd, 32'h2);
    lb_write(32'h18, 32'h2);

    // Same-cycle write and read of ADDR returns the old value
    lb_addr = 32'h10; lb_wr_d = 32'h77; lb_wr = 1'b1; lb_rd = 1'b1;
    tick(1);
    lb_wr = 1'b0; lb_rd = 1'b0;
    chk("rw_rdy", {31'd0, lb_rd_rdy}, 32'd1);
    chk("rw_old", lb_rd_d, 32'h5);
    lb_read(32'h10, rd); chk("rw_new", rd, 32'h77);

    // Unmapped and write-only addresses read as zero
    lb_read(32'h24, rd); chk("unmapped", rd, 32'h0);
    lb_read(32'h1C, rd); chk("cmd_wo", rd, 32'h0);

    // Reset while waiting for read data
    lb_write(32'h1C, 32'h4);
    pulse_ack();
    lb_read(32'h18, rd); chk("wait_status", rd, 32'h1);
    reset_n = 1'b0;
    #2;
    chk("arst_req", {31'd0, hr_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rdy", {31'd0, lb_rd_rdy}, 32'd0);
    chk("arst_rd_d", lb_rd_d, 32'd0);
    chk("arst_hr_addr", hr_addr, 32'd0);
    #10 reset_n = 1'b1;
    tick(1);
    pulse_rvalid(32'hCAFE_F00D);
    chk("late_rvalid_idle", {31'd0, busy}, 32'd0);
    lb_read(32'h14, rd); chk("late_rdata", rd, 32'h0);
    lb_read(32'h10, rd); chk("arst_addr_reg", rd, 32'h0);
    lb_read(32'h20, rd); chk("arst_count", rd, 32'h0);
    lb_read(32'h18, rd); chk("arst_status", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
